fir_tap_loader: RTL and testbench

FIR_TAP_LOADER -- requirements
Module: fir_tap_loader

---
 rtl/fir_tap_loader.sv | 156 +++++++++++++++
 tb/tb_fir_tap_loader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_loader.sv
// Coefficient loader: takes NTAPS coefficients from a valid-qualified stream,
// forwards each to a tap chain one cycle later, and tracks count, sum and timeout.
module fir_tap_loader #(
  parameter int NTAPS   = 5,
  parameter int TW      = 12,
  parameter int TIMEOUT = 1024
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic                       i_valid,
  input  logic [TW-1:0]              i_coef,
  output logic                       o_ready,
  output logic                       o_tap_wr,
  output logic [TW-1:0]              o_tap,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_err,
  output logic [$clog2(NTAPS+1)-1:0] o_count,
  output logic [TW+7:0]              o_sum
);

  localparam int CW = $clog2(NTAPS + 1);
  localparam int IW = $clog2(TIMEOUT);
  localparam int SW = TW + 8;
  localparam logic [CW-1:0] LAST_CNT = CW'(NTAPS - 1);
  // Abort fires on the idle cycle that would bring the counter to TIMEOUT-1.
  localparam logic [IW-1:0] IDLE_LIM = IW'(TIMEOUT - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            ready_s, busy_s, accept_s;
  logic            tap_wr_q, tap_wr_d;
  logic [TW-1:0]   tap_q, tap_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SW-1:0]   sum_q, sum_d;
  logic [IW-1:0]   idle_q, idle_d;

  assign accept_s = i_valid & ready_s;

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) state_d = S_LOAD;
        else         state_d = S_IDLE;
      end
      S_LOAD: begin
        if (accept_s && (count_q == LAST_CNT))      state_d = S_FIN;
        else if (!accept_s && (idle_q == IDLE_LIM)) state_d = S_IDLE;
        else                                        state_d = S_LOAD;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    ready_s = 1'b0;
    busy_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_s = 1'b0;
        busy_s  = 1'b0;
      end
      S_LOAD: begin
        ready_s = 1'b1;
        busy_s  = 1'b1;
      end
      S_FIN: begin
        ready_s = 1'b0;
        busy_s  = 1'b1;
      end
      default: begin
        ready_s = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Datapath next values; an accept always wins over a timeout
  always_comb begin
    tap_wr_d = accept_s;
    tap_d    = accept_s ? i_coef : tap_q;
    done_d   = (state_q == S_FIN);
    err_d    = err_q;
    count_d  = count_q;
    sum_d    = sum_q;
    idle_d   = idle_q;
    if ((state_q == S_IDLE) && i_start) begin
      err_d   = 1'b0;
      count_d = {CW{1'b0}};
      sum_d   = {SW{1'b0}};
      idle_d  = {IW{1'b0}};
    end else if (accept_s) begin
      count_d = count_q + 1'b1;
      sum_d   = sum_q + {8'd0, i_coef};
      idle_d  = {IW{1'b0}};
    end else if (state_q == S_LOAD) begin
      idle_d = idle_q + 1'b1;
      if (idle_q == IDLE_LIM) err_d = 1'b1;
      else                    err_d = err_q;
    end else begin
      idle_d = idle_q;
    end
  end

  // Datapath registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tap_wr_q <= 1'b0;
      tap_q    <= {TW{1'b0}};
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= {CW{1'b0}};
      sum_q    <= {SW{1'b0}};
      idle_q   <= {IW{1'b0}};
    end else begin
      tap_wr_q <= tap_wr_d;
      tap_q    <= tap_d;
      done_q   <= done_d;
      err_q    <= err_d;
      count_q  <= count_d;
      sum_q    <= sum_d;
      idle_q   <= idle_d;
    end
  end

  assign o_ready  = ready_s;
  assign o_busy   = busy_s;
  assign o_tap_wr = tap_wr_q;
  assign o_tap    = tap_q;
  assign o_done   = done_q;
  assign o_err    = err_q;
  assign o_count  = count_q;
  assign o_sum    = sum_q;

endmodule

// File: tb/tb_fir_tap_loader.sv
// Bench for fir_tap_loader: directed table of loads, reset-abort sequence and
// randomized loads, all checked against a cycle-indexed model of the load rules.
module tb_fir_tap_loader;

  localparam int NTAPS   = 5;
  localparam int TW      = 12;
  localparam int TIMEOUT = 8;
  localparam int CW      = $clog2(NTAPS + 1);
  localparam int SW      = TW + 8;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_start = 1'b0;
  logic          i_valid = 1'b0;
  logic [TW-1:0] i_coef = '0;
  logic          o_ready, o_tap_wr, o_busy, o_done, o_err;
  logic [TW-1:0] o_tap;
  logic [CW-1:0] o_count;
  logic [SW-1:0] o_sum;

  int checks = 0;
  int failures = 0;
  logic [TW-1:0] exp_tap = '0;

  fir_tap_loader #(.NTAPS(NTAPS), .TW(TW), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_valid(i_valid),
    .i_coef(i_coef), .o_ready(o_ready), .o_tap_wr(o_tap_wr), .o_tap(o_tap),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_count(o_count),
    .o_sum(o_sum)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ready"}, o_ready, 0);
    chk({nm, "_tap_wr"}, o_tap_wr, 0);
    chk({nm, "_tap"}, o_tap, 0);
    chk({nm, "_busy"}, o_busy, 0);
    chk({nm, "_done"}, o_done, 0);
    chk({nm, "_err"}, o_err, 0);
    chk({nm, "_count"}, o_count, 0);
    chk({nm, "_sum"}, o_sum, 0);
  endtask

  // Runs one load; must be called at a falling edge. vm bit k = i_valid at the
  // k-th rising edge after the start edge. A new coefficient is presented after
  // each cycle in which the source drove valid.
  task automatic run_load(input logic [63:0] vm, input logic [TW-1:0] base,
                          input logic [TW-1:0] step, input bit rnd_start,
                          input bit chain, output int n_o,
                          output logic [SW-1:0] s_o, output bit to_o);
    logic [TW-1:0] cc[64];
    bit            acc[64];
    int            end_k, n, idle, last_k;
    bit            to;
    logic [TW-1:0] nxt;
    logic [SW-1:0] s;
    end_k = -1; n = 0; idle = 0; to = 1'b0; nxt = base; s = '0;
    for (int k = 0; k < 64; k++) begin
      cc[k] = nxt;
      acc[k] = 1'b0;
      if (k >= 1) begin
        if (end_k < 0) begin
          if (vm[k]) begin
            acc[k] = 1'b1;
            n++;
            s = s + SW'(cc[k]);
            idle = 0;
            if (n == NTAPS) end_k = k;
          end else begin
            idle++;
            if (idle == TIMEOUT - 1) begin
              end_k = k;
              to = 1'b1;
            end
          end
        end
        if (vm[k]) nxt = nxt + step;
      end
    end
    n_o = n; s_o = s; to_o = to;
    if (end_k < 0 || end_k > 60) begin
      chk("model_end_in_budget", end_k, 1);
      return;
    end
    i_start = 1'b1; i_valid = 1'b0; i_coef = '0;
    @(negedge i_clk);
    chk("start_busy", o_busy, 1);
    chk("start_ready", o_ready, 1);
    chk("start_err_clr", o_err, 0);
    chk("start_count_clr", o_count, 0);
    chk("start_sum_clr", o_sum, 0);
    last_k = (chain && !to) ? end_k + 1 : end_k + 2;
    for (int k = 1; k <= last_k; k++) begin
      i_start = (rnd_start && k <= end_k) ? 1'($urandom_range(0, 1)) : 1'b0;
      i_valid = vm[k];
      i_coef  = cc[k];
      @(negedge i_clk);
      if (acc[k]) exp_tap = cc[k];
      chk("tap_wr", o_tap_wr, acc[k]);
      chk("tap", o_tap, exp_tap);
      chk("ready", o_ready, k < end_k);
      chk("busy", o_busy, (k < end_k) || (k == end_k && !to));
      chk("done", o_done, !to && k == end_k + 1);
      chk("err", o_err, to && k >= end_k);
    end
    i_start = 1'b0; i_valid = 1'b0;
    chk("final_count", o_count, n);
    chk("final_sum", o_sum, s);
  endtask

  typedef struct {
    logic [63:0]   vm;
    logic [TW-1:0] base;
    logic [TW-1:0] step;
    int            exp_n;
    logic [SW-1:0] exp_sum;
    bit            exp_err;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int            n;
    logic [SW-1:0] s;
    bit            to;

    tbl[0] = '{64'h0000_0000_0000_003E, 12'h001, 12'h001, 5, 20'h0000F, 1'b0};
    tbl[1] = '{64'hAAAA_AAAA_AAAA_AAAA, 12'h001, 12'h001, 5, 20'h0000F, 1'b0};
    tbl[2] = '{64'h0000_0000_0000_0006, 12'h001, 12'h001, 2, 20'h00003, 1'b1};
    tbl[3] = '{64'h0000_0000_0000_00FE, 12'h001, 12'h001, 5, 20'h0000F, 1'b0};
    tbl[4] = '{64'h0000_0000_0000_003E, 12'hFFF, 12'h000, 5, 20'h04FFB, 1'b0};

    #1;
    chk_all_zero("reset");
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    // First start right after reset release must be taken on the next edge.
    for (int i = 0; i < 5; i++) begin
      run_load(tbl[i].vm, tbl[i].base, tbl[i].step, 1'b0, 1'b0, n, s, to);
      chk("tbl_count", o_count, tbl[i].exp_n);
      chk("tbl_sum", o_sum, tbl[i].exp_sum);
      chk("tbl_err", o_err, tbl[i].exp_err);
    end

    // Start issued in the done cycle begins the next load immediately.
    run_load(64'h0000_0000_0000_003E, 12'h010, 12'h003, 1'b0, 1'b1, n, s, to);
    run_load(64'h0000_0000_0000_0F3E, 12'h100, 12'h011, 1'b0, 1'b0, n, s, to);

    // Reset after the third accept: everything clears at once, no done.
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      i_valid = 1'b1;
      i_coef = TW'(j);
      @(negedge i_clk);
    end
    chk("midload_count", o_count, 3);
    #1 i_reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    exp_tap = '0;
    @(negedge i_clk);
    i_reset = 1'b0;
    i_valid = 1'b0;
    @(negedge i_clk);
    chk("post_reset_tap_wr", o_tap_wr, 0);
    chk("post_reset_done", o_done, 0);
    chk("post_reset_busy", o_busy, 0);
    run_load(64'h0000_0000_0000_003E, 12'h001, 12'h001, 1'b0, 1'b0, n, s, to);
    chk("fresh_load_sum", o_sum, 20'h0000F);

    for (int r = 0; r < 30; r++) begin
      run_load({$urandom, $urandom}, TW'($urandom), TW'($urandom), 1'b1,
               1'($urandom_range(0, 1)), n, s, to);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
